boot_loader: RTL and testbench

Serial boot controller that owns the core's data-memory port out of reset: it receives a framed program image byte-by-byte from a UART receiver, writes it word-by-word into the shared RAM, verifies a checksum, then releases the `torv32` core from reset. Once the core is running, the RAM port is handed to the core's data interface. It sits between the UART RX, the core's `mem_*` outputs and the RAM write port, and drives the core's `resetn`.

---
 rtl/boot_loader.sv | 134 +++++++++++++
 tb/tb_boot_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Serial boot loader: receives a framed image over UART, writes it into RAM,
// verifies an 8-bit data checksum, then releases the core and hands it the RAM port.
module boot_loader #(
    parameter int unsigned MAX_WORDS = 2097152
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_wdata,
    input  logic [3:0]  core_mem_wmask,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    output logic        core_resetn,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_BASE = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]  state;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [31:0] len_q;
    logic [31:0] addr_q;
    logic [23:0] field;
    logic [7:0]  sum;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [31:0] field_next;
    logic        last_byte;

    // Little-endian assembly: the incoming byte lands on top, older bytes shift down.
    always_comb begin
        field_next = {rx_data, field};
        last_byte  = (byte_cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LEN;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            field       <= '0;
            sum         <= '0;
            ld_we       <= 1'b0;
            ld_addr     <= '0;
            ld_wdata    <= '0;
            core_resetn <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ld_we    <= 1'b0;
            ld_addr  <= '0;
            ld_wdata <= '0;
            if (rx_valid) begin
                case (state)
                    S_LEN: begin
                        field    <= field_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            if (field_next == 32'd0) begin
                                state <= S_CSUM;
                            end else if (field_next > MAX_WORDS) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else begin
                                len_q <= field_next;
                                state <= S_BASE;
                            end
                        end
                    end
                    S_BASE: begin
                        field    <= field_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            addr_q <= {field_next[31:2], 2'b00};
                            state  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        field    <= field_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        sum      <= sum + rx_data;
                        if (last_byte) begin
                            ld_we    <= 1'b1;
                            ld_addr  <= addr_q;
                            ld_wdata <= field_next;
                            addr_q   <= addr_q + 32'd4;
                            word_cnt <= word_cnt + 32'd1;
                            if (word_cnt + 32'd1 == len_q) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == sum) begin
                            state       <= S_RUN;
                            done        <= 1'b1;
                            core_resetn <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        if (state == S_RUN) begin
            ram_addr  = core_mem_addr;
            ram_wdata = core_mem_wdata;
            ram_wmask = core_mem_wmask;
        end else begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
            ram_wmask = ld_we ? 4'b1111 : 4'b0000;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: frame-level reference model checked every cycle,
// plus directed images with literal expectations.
module tb_boot_loader;

    localparam longint unsigned MAXW = 2097152;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [31:0] core_mem_addr = '0;
    logic [31:0] core_mem_wdata = '0;
    logic [3:0]  core_mem_wmask = '0;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wmask;
    logic        core_resetn;
    logic        done;
    logic        err;

    boot_loader #(.MAX_WORDS(2097152)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .core_mem_wmask(core_mem_wmask), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wmask(ram_wmask), .core_resetn(core_resetn), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    longint cyc = 0;
    longint first_cyc = -1;
    longint done_cyc = -1;
    logic [63:0] wr_log[$];

    // Reference model: the bytes of the current frame, interpreted by position.
    logic [7:0]        q[$];
    bit                m_run = 1'b0, m_err = 1'b0, m_we = 1'b0;
    logic [31:0]       m_addr = '0, m_wdata = '0, m_base;
    longint unsigned   m_n, m_csum_idx;
    int                m_k, m_widx;
    logic [7:0]        m_sum;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        if (reset) begin
            q.delete(); m_run = 1'b0; m_err = 1'b0;
        end else if (rx_valid && !m_run && !m_err) begin
            q.push_back(rx_data);
            m_k = q.size() - 1;
            if (m_k >= 3) begin
                m_n = longint'({q[3], q[2], q[1], q[0]});
                m_csum_idx = (m_n == 0) ? 4 : 8 + 4 * m_n;
                if (m_k == 3) begin
                    if (m_n > MAXW) m_err = 1'b1;
                end else if (longint'(m_k) == m_csum_idx) begin
                    m_sum = '0;
                    for (int i = 8; i < m_k; i++) m_sum = m_sum + q[i];
                    if (rx_data == m_sum) m_run = 1'b1; else m_err = 1'b1;
                end else if (m_k >= 8 && ((m_k - 8) % 4) == 3) begin
                    m_widx  = (m_k - 8) / 4;
                    m_base  = {q[7], q[6], q[5], q[4]} & 32'hFFFF_FFFC;
                    m_we    = 1'b1;
                    m_addr  = m_base + 32'(4 * m_widx);
                    m_wdata = {q[m_k], q[m_k-1], q[m_k-2], q[m_k-3]};
                end
            end
        end
    end

    logic [70:0] exp_v, got_v;
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_run)
                exp_v = {core_mem_addr, core_mem_wdata, core_mem_wmask, 1'b1, 1'b1, 1'b0};
            else
                exp_v = {m_addr, m_wdata, (m_we ? 4'hF : 4'h0), 1'b0, 1'b0, m_err};
            got_v = {ram_addr, ram_wdata, ram_wmask, core_resetn, done, err};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL cycle_model t=%0t got addr/wdata/wmask/rstn/done/err=%h expected %h",
                         $time, got_v, exp_v);
            end
            if (ram_wmask == 4'hF && !done) wr_log.push_back({ram_addr, ram_wdata});
            if (done && done_cyc < 0) done_cyc = cyc;
            if (rx_valid && first_cyc < 0) first_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    task automatic rand_core();
        core_mem_addr  = $urandom;
        core_mem_wdata = $urandom;
        core_mem_wmask = 4'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1; rx_data = b; rand_core();
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom);
        repeat (gap) begin rand_core(); @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin rand_core(); @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'($urandom); rx_data = 8'($urandom);
        @(posedge clk); #1;
        reset = 1'b0; rx_valid = 1'b0;
        wr_log.delete(); first_cyc = -1; done_cyc = -1;
    endtask

    // gap_mode 0: back-to-back, 1: gapped (last byte never gapped), 2: random.
    task automatic send_frame(input logic [7:0] fr[$], input int gap_mode);
        int g;
        foreach (fr[i]) begin
            g = (gap_mode == 0 || i == fr.size() - 1) ? 0 :
                (gap_mode == 1) ? 1 + int'($urandom % 3) : int'($urandom % 3);
            send_byte(fr[i], g);
        end
    endtask

    logic [7:0] img[$];
    logic [7:0] fr[$];
    logic [7:0] s;
    int n;
    logic [31:0] base;

    initial begin
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4B};
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_reset();
        check("reset_resetn", 64'(core_resetn), 64'd0);
        check("reset_wmask", 64'(ram_wmask), 64'd0);
        check("reset_addr", 64'(ram_addr), 64'd0);

        // Valid image, gapped bytes
        send_frame(img, 1);
        check("t1_done", 64'({done, core_resetn}), 64'd3);
        core_mem_addr = 32'h0000_0200; core_mem_wdata = 32'hCAFE_F00D; core_mem_wmask = 4'b0011;
        #1;
        check("t1_pass", {ram_addr, ram_wdata}, {32'h0000_0200, 32'hCAFE_F00D});
        check("t1_pass_mask", 64'(ram_wmask), 64'h3);
        idle(2);
        check("t1_nwr", 64'(wr_log.size()), 64'd2);
        check("t1_w0", wr_log[0], {32'h100, 32'h13});
        check("t1_w1", wr_log[1], {32'h104, 32'hDEADBEEF});

        // Same image back-to-back
        do_reset();
        send_frame(img, 0);
        idle(2);
        check("t2_nwr", 64'(wr_log.size()), 64'd2);
        check("t2_w1", wr_log[1], {32'h104, 32'hDEADBEEF});
        check("t2_release", 64'(done_cyc - first_cyc), 64'd17);

        // Empty image
        do_reset();
        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 2);
        check("t3_done", 64'(done), 64'd1);
        idle(2);
        check("t3_nwr", 64'(wr_log.size()), 64'd0);

        // Bad checksum
        do_reset();
        fr = img; fr[16] = 8'h4C;
        send_frame(fr, 2);
        send_frame(img, 0);
        idle(2);
        check("t4_nwr", 64'(wr_log.size()), 64'd2);
        check("t4_flags", 64'({err, core_resetn, done}), 64'h4);

        // Oversized count, then the largest legal count
        do_reset();
        fr = '{8'h01, 8'h00, 8'h20, 8'h00};
        send_frame(fr, 0);
        check("t5_err", 64'(err), 64'd1);
        send_frame(img, 0);
        idle(2);
        check("t5_nwr", 64'(wr_log.size()), 64'd0);
        do_reset();
        fr = '{8'h00, 8'h00, 8'h20, 8'h00};
        send_frame(fr, 0);
        check("t5_max_ok", 64'(err), 64'd0);

        // Reset after 6 DATA bytes, then clean reload
        do_reset();
        fr = img[0:13];
        send_frame(fr, 2);
        idle(1);
        check("t6_partial", 64'(wr_log.size()), 64'd1);
        check("t6_w0", wr_log[0], {32'h100, 32'h13});
        do_reset();
        send_frame(img, 1);
        check("t6_done", 64'({done, core_resetn}), 64'd3);
        idle(2);
        check("t6_nwr", 64'(wr_log.size()), 64'd2);

        // Random frames: small counts, wrapping bases, random checksums and trailers
        for (int r = 0; r < 60; r++) begin
            do_reset();
            n = int'($urandom % 5);
            base = ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            fr.delete();
            if ($urandom % 8 == 0) begin
                n = int'(MAXW) + 1 + int'($urandom % 4);
            end
            for (int b = 0; b < 4; b++) fr.push_back(8'(n >> (8 * b)));
            if (n > 0 && n <= int'(MAXW)) begin
                for (int b = 0; b < 4; b++) fr.push_back(8'(base >> (8 * b)));
                for (int b = 0; b < 4 * n; b++) fr.push_back(8'($urandom));
            end
            s = '0;
            for (int b = 8; b < fr.size(); b++) s = s + fr[b];
            fr.push_back(($urandom % 4 == 0) ? 8'(s + 8'(1 + $urandom % 255)) : s);
            for (int b = 0; b < int'($urandom % 4); b++) fr.push_back(8'($urandom));
            if ($urandom % 8 == 0) begin
                fr = fr[0:int'($urandom % fr.size())];
            end
            send_frame(fr, 2);
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
